// File: rtl/gpt_pkg.sv
// Shared timer definitions: capture polarity/prescaler encodings and counter width.
package gpt_pkg;

  localparam int GPT_CNT_W = 16;

  typedef enum logic [1:0] {
    IC_POL_RISE = 2'b00,
    IC_POL_FALL = 2'b01,
    IC_POL_RSVD = 2'b10,
    IC_POL_BOTH = 2'b11
  } ic_pol_e;

  typedef enum logic [1:0] {
    IC_PSC_1 = 2'b00,
    IC_PSC_2 = 2'b01,
    IC_PSC_4 = 2'b10,
    IC_PSC_8 = 2'b11
  } ic_psc_e;

  // Terminal prescaler count (div-1) for a given ratio.
  function automatic logic [2:0] psc_last(input ic_psc_e psc);
    case (psc)
      IC_PSC_1: psc_last = 3'd0;
      IC_PSC_2: psc_last = 3'd1;
      IC_PSC_4: psc_last = 3'd3;
      default:  psc_last = 3'd7;
    endcase
  endfunction

endpackage

// File: rtl/edge_detector.sv
// Registers the filtered channel level and reports rising, falling and
// polarity-selected edges combinationally against the registered copy.
module edge_detector
  import gpt_pkg::*;
(
  input  logic    clk_i,
  input  logic    aresetn_i,
  input  logic    af_i,
  input  ic_pol_e pol_i,
  output logic    rise_o,
  output logic    fall_o,
  output logic    edge_o
);

  logic af_q;

  always_ff @(posedge clk_i or negedge aresetn_i) begin
    if (!aresetn_i) begin
      af_q <= 1'b0;
    end else begin
      af_q <= af_i;
    end
  end

  assign rise_o = af_i & ~af_q;
  assign fall_o = ~af_i & af_q;

  // The reserved encoding falls back to rising-edge capture.
  always_comb begin
    edge_o = rise_o;
    case (pol_i)
      IC_POL_FALL: edge_o = fall_o;
      IC_POL_BOTH: edge_o = rise_o | fall_o;
      default:     edge_o = rise_o;
    endcase
  end

endmodule

// File: rtl/input_capture_channel.sv
// Timer channel capture stage: edge prescaling, counter capture and flags.
// Overcapture flag present only when ICAP_OVERCAPTURE_EN is defined.
module input_capture_channel
  import gpt_pkg::*;
#(
  parameter int CNT_W = GPT_CNT_W
) (
  input  logic             clk_i,
  input  logic             aresetn_i,
  input  logic             af_i,
  input  logic [CNT_W-1:0] cnt_i,
  input  logic             cc_en_i,
  input  logic [1:0]       pol_i,
  input  logic [1:0]       psc_i,
  input  logic             ccif_clr_i,
  input  logic             ccof_clr_i,
  output logic [CNT_W-1:0] ccr_o,
  output logic             ccif_o,
  output logic             ccof_o,
  output logic             cap_pulse_o
);

  logic             rise;
  logic             fall;
  logic             edge_sel;
  logic             unused_edges;
  logic [1:0]       psc_q;
  logic [2:0]       psc_cnt_q;
  logic [2:0]       psc_cnt_d;
  logic [2:0]       psc_cur;
  logic             psc_chg;
  logic             qev;
  logic [CNT_W-1:0] ccr_q;
  logic [CNT_W-1:0] ccr_d;
  logic             ccif_q;
  logic             ccif_d;
  logic             cap_q;

  edge_detector u_edge (
    .clk_i    (clk_i),
    .aresetn_i(aresetn_i),
    .af_i     (af_i),
    .pol_i    (ic_pol_e'(pol_i)),
    .rise_o   (rise),
    .fall_o   (fall),
    .edge_o   (edge_sel)
  );

  assign unused_edges = rise ^ fall;

  // A ratio change restarts the count; an edge in that cycle is its first edge.
  assign psc_chg = (psc_i != psc_q);
  assign psc_cur = psc_chg ? 3'd0 : psc_cnt_q;
  assign qev     = cc_en_i & edge_sel & (psc_cur == psc_last(ic_psc_e'(psc_i)));

  always_comb begin
    psc_cnt_d = psc_cur;
    if (!cc_en_i) begin
      psc_cnt_d = 3'd0;
    end else if (edge_sel) begin
      psc_cnt_d = qev ? 3'd0 : 3'(psc_cur + 3'd1);
    end
  end

  assign ccr_d  = qev ? cnt_i : ccr_q;
  assign ccif_d = qev | (ccif_q & ~ccif_clr_i);

  always_ff @(posedge clk_i or negedge aresetn_i) begin
    if (!aresetn_i) begin
      psc_q     <= 2'b00;
      psc_cnt_q <= 3'd0;
      ccr_q     <= '0;
      ccif_q    <= 1'b0;
      cap_q     <= 1'b0;
    end else begin
      psc_q     <= psc_i;
      psc_cnt_q <= psc_cnt_d;
      ccr_q     <= ccr_d;
      ccif_q    <= ccif_d;
      cap_q     <= qev;
    end
  end

`ifdef ICAP_OVERCAPTURE_EN
  logic ccof_q;
  logic ccof_d;

  // A clear arriving with the capture acknowledges the old one: no overcapture.
  assign ccof_d = (qev & ccif_q & ~ccif_clr_i) | (ccof_q & ~ccof_clr_i);

  always_ff @(posedge clk_i or negedge aresetn_i) begin
    if (!aresetn_i) begin
      ccof_q <= 1'b0;
    end else begin
      ccof_q <= ccof_d;
    end
  end

  assign ccof_o = ccof_q;
`else
  logic unused_ccof_clr;

  assign unused_ccof_clr = ccof_clr_i;
  assign ccof_o          = 1'b0;
`endif

  assign ccr_o       = ccr_q;
  assign ccif_o      = ccif_q;
  assign cap_pulse_o = cap_q;

endmodule

// File: tb/tb_input_capture_channel.sv
// Scoreboard bench for input_capture_channel: stimulus queues expected captures,
// a monitor checks them on each cap_pulse_o.
module tb_input_capture_channel;
  import gpt_pkg::*;

  localparam int W = 16;
`ifdef ICAP_OVERCAPTURE_EN
  localparam bit OC = 1'b1;
`else
  localparam bit OC = 1'b0;
`endif

  logic         clk_i = 1'b0;
  logic         aresetn_i;
  logic         af_i;
  logic [W-1:0] cnt_i;
  logic         cc_en_i;
  logic [1:0]   pol_i;
  logic [1:0]   psc_i;
  logic         ccif_clr_i;
  logic         ccof_clr_i;
  logic [W-1:0] ccr_o;
  logic         ccif_o;
  logic         ccof_o;
  logic         cap_pulse_o;

  typedef struct packed {
    logic [W-1:0] ccr;
    logic         ccif;
    logic         ccof;
  } exp_t;

  exp_t exp_q[$];
  int   vectors     = 0;
  int   miscompares = 0;

  input_capture_channel #(.CNT_W(W)) dut (
    .clk_i      (clk_i),
    .aresetn_i  (aresetn_i),
    .af_i       (af_i),
    .cnt_i      (cnt_i),
    .cc_en_i    (cc_en_i),
    .pol_i      (pol_i),
    .psc_i      (psc_i),
    .ccif_clr_i (ccif_clr_i),
    .ccof_clr_i (ccof_clr_i),
    .ccr_o      (ccr_o),
    .ccif_o     (ccif_o),
    .ccof_o     (ccof_o),
    .cap_pulse_o(cap_pulse_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: every capture strobe must match the oldest expected capture.
  always @(negedge clk_i) begin
    exp_t e;
    if (cap_pulse_o === 1'b1) begin
      if (exp_q.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL unexpected_capture: got ccr=%h ccif=%b ccof=%b expected no capture",
                 ccr_o, ccif_o, ccof_o);
      end else begin
        e = exp_q.pop_front();
        $display("capture ccr=%h ccif=%b ccof=%b (expected ccr=%h ccif=%b ccof=%b)",
                 ccr_o, ccif_o, ccof_o, e.ccr, e.ccif, e.ccof);
        chk("cap_ccr", 32'(ccr_o), 32'(e.ccr));
        chk("cap_ccif", 32'(ccif_o), 32'(e.ccif));
        chk("cap_ccof", 32'(ccof_o), 32'(e.ccof));
      end
    end
  end

  // One clock of stimulus; if a capture is expected from it, queue the result.
  task automatic tx(input logic a, input logic [W-1:0] cnt, input bit cap, input bit eccof,
                    input logic iclr = 1'b0, input logic oclr = 1'b0);
    exp_t e;
    @(posedge clk_i);
    #1;
    af_i       = a;
    cnt_i      = cnt;
    ccif_clr_i = iclr;
    ccof_clr_i = oclr;
    if (cap) begin
      e.ccr  = cnt;
      e.ccif = 1'b1;
      e.ccof = eccof;
      exp_q.push_back(e);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk_i);
      #1;
      ccif_clr_i = 1'b0;
      ccof_clr_i = 1'b0;
    end
  endtask

  task automatic drain(input string name);
    idle(3);
    chk(name, 32'(exp_q.size()), 32'd0);
    exp_q.delete();
  endtask

  task automatic clear_flags(input string name);
    @(posedge clk_i);
    #1;
    ccif_clr_i = 1'b1;
    ccof_clr_i = 1'b1;
    idle(1);
    chk({name, "_ccif"}, 32'(ccif_o), 32'd0);
    chk({name, "_ccof"}, 32'(ccof_o), 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    aresetn_i  = 1'b0;
    af_i       = 1'b0;
    cnt_i      = '0;
    cc_en_i    = 1'b0;
    pol_i      = 2'b00;
    psc_i      = 2'b00;
    ccif_clr_i = 1'b0;
    ccof_clr_i = 1'b0;
    repeat (2) @(posedge clk_i);
    #1;
    chk("rst_ccr", 32'(ccr_o), 32'd0);
    chk("rst_ccif", 32'(ccif_o), 32'd0);
    chk("rst_ccof", 32'(ccof_o), 32'd0);
    chk("rst_pulse", 32'(cap_pulse_o), 32'd0);
    aresetn_i = 1'b1;
    idle(1);

    // Rising-edge capture; the falling edge must not capture.
    cc_en_i = 1'b1;
    idle(1);
    tx(1'b1, 16'h1234, 1, 1'b0);
    tx(1'b0, 16'h1111, 0, 1'b0);
    drain("t1_pending");
    chk("t1_ccif_sticky", 32'(ccif_o), 32'd1);
    chk("t1_ccr_hold", 32'(ccr_o), 32'h1234);
    clear_flags("t1_clr");

    // Both edges, divide by 4: captures on edges 4 and 8 (edge 8 at counter wrap value).
    pol_i = 2'b11;
    psc_i = 2'b10;
    idle(1);
    for (int i = 1; i <= 8; i++) begin
      tx(logic'(i[0]), (i == 8) ? 16'hFFFF : W'(16'h2000 + i), (i % 4) == 0, (i == 8) && OC);
    end
    drain("t2_pending");
    chk("t2_ccr_wrap", 32'(ccr_o), 32'hFFFF);
    clear_flags("t2_clr");

    // Overcapture and flag priority.
    pol_i = 2'b00;
    psc_i = 2'b00;
    idle(1);
    tx(1'b1, 16'h3001, 1, 1'b0);
    tx(1'b0, 16'h0000, 0, 1'b0);
    tx(1'b1, 16'h3002, 1, OC);
    idle(1);
    chk("t3_ccof_set", 32'(ccof_o), 32'(OC));
    drain("t3_pending_a");
    clear_flags("t3_clr_a");
    tx(1'b0, 16'h0000, 0, 1'b0);
    tx(1'b1, 16'h3003, 1, 1'b0);
    tx(1'b0, 16'h0000, 0, 1'b0);
    tx(1'b1, 16'h3004, 1, 1'b0, 1'b1, 1'b0);
    tx(1'b0, 16'h0000, 0, 1'b0);
    chk("t3_ccif_set_wins", 32'(ccif_o), 32'd1);
    chk("t3_no_oc_on_clr", 32'(ccof_o), 32'd0);
    tx(1'b1, 16'h3005, 1, OC, 1'b0, 1'b1);
    idle(1);
    chk("t3_oc_beats_clr", 32'(ccof_o), 32'(OC));
    drain("t3_pending_b");
    clear_flags("t3_clr_b");

    // Edge while disabled, then enabling with af high: no capture.
    cc_en_i = 1'b0;
    tx(1'b0, 16'h0000, 0, 1'b0);
    tx(1'b1, 16'h0000, 0, 1'b0);
    idle(2);
    cc_en_i = 1'b1;
    idle(3);
    drain("t4_enable_pending");
    chk("t4_enable_no_cap", 32'(ccif_o), 32'd0);

    // One edge at divide-by-2, switch to divide-by-8: capture on 8th new edge.
    psc_i = 2'b01;
    idle(1);
    tx(1'b0, 16'h0000, 0, 1'b0);
    tx(1'b1, 16'h0000, 0, 1'b0);
    idle(1);
    psc_i = 2'b11;
    idle(1);
    for (int i = 1; i <= 8; i++) begin
      tx(1'b0, 16'h0000, 0, 1'b0);
      tx(1'b1, W'(16'h4000 + i), i == 8, 1'b0);
    end
    drain("t4_psc_pending");

    // Reset while three edges into a divide-by-8.
    for (int i = 1; i <= 3; i++) begin
      tx(1'b0, 16'h0000, 0, 1'b0);
      tx(1'b1, 16'h0000, 0, 1'b0);
    end
    @(posedge clk_i);
    #2;
    aresetn_i = 1'b0;
    af_i      = 1'b0;
    #1;
    chk("t5_rst_ccr", 32'(ccr_o), 32'd0);
    chk("t5_rst_ccif", 32'(ccif_o), 32'd0);
    chk("t5_rst_ccof", 32'(ccof_o), 32'd0);
    chk("t5_rst_pulse", 32'(cap_pulse_o), 32'd0);
    idle(2);
    aresetn_i = 1'b1;
    idle(1);
    for (int i = 1; i <= 8; i++) begin
      tx(1'b1, W'(16'h5000 + i), i == 8, 1'b0);
      tx(1'b0, 16'h0000, 0, 1'b0);
    end
    drain("t5_pending");
    chk("t5_ccr", 32'(ccr_o), 32'h5008);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
